// File: rtl/alu_pkg.sv
// Shared definitions for the shift datapath.
// shift_mode_e : the 2-bit operation encoding carried with every operation.
// stage_ctrl_t : control part of a pipeline stage register (valid, mode, carry).
//                The width-dependent fields (data, remaining shift amount) are
//                kept in the owning module because they depend on its WIDTH.
// stage_bits/stage_lo/stage_hi : how the shift-amount bits are split across stages.
package alu_pkg;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_mode_e;

  typedef struct packed {
    logic        valid;
    shift_mode_e mode;
    logic        carry;
  } stage_ctrl_t;

  // Shift-amount bits handled per stage: ceil(shw / stages).
  function automatic int stage_bits(input int shw, input int stages);
    return (shw + stages - 1) / stages;
  endfunction

  // First shift-amount bit handled by stage k.
  function automatic int stage_lo(input int shw, input int stages, input int k);
    return k * stage_bits(shw, stages);
  endfunction

  // One past the last shift-amount bit handled by stage k (clamped to shw,
  // so the final stage takes whatever remains, possibly nothing).
  function automatic int stage_hi(input int shw, input int stages, input int k);
    int hi;
    hi = (k + 1) * stage_bits(shw, stages);
    return (hi > shw) ? shw : hi;
  endfunction

endpackage

// File: rtl/barrel_shifter_pipe_if.sv
// Request/response bundle of the pipelined barrel shifter.
// Request side : in_valid, in_ready, in_data[WIDTH], in_shamt[SHW], in_mode[2]
// Response side: out_valid, out_ready, out_data[WIDTH], out_carry, out_zero
// master = producer of requests / consumer of results, slave = the shifter.
interface barrel_shifter_pipe_if #(
  parameter int WIDTH = 16
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [1:0]       in_mode;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero
  );

endinterface

// File: rtl/shift_stage.sv
// Combinational slice of the barrel shifter: applies the binary-weighted
// sub-shifts selected by shift-amount bits [LO, HI) of shamt_in, in LSB-first
// order, to data_in. Each applied sub-shift updates the carry; bits consumed
// here are cleared in shamt_out so the next stage sees only what remains.
// Ports: data_in/data_out [WIDTH], shamt_in/shamt_out [SHW], mode,
//        carry_in/carry_out.
module shift_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = 4,
  parameter int LO    = 0,
  parameter int HI    = 2
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt_in,
  input  shift_mode_e      mode,
  input  logic             carry_in,
  output logic [WIDTH-1:0] data_out,
  output logic [SHW-1:0]   shamt_out,
  output logic             carry_out
);

  int unsigned amt;

  always_comb begin
    data_out  = data_in;
    carry_out = carry_in;
    shamt_out = shamt_in;
    amt       = 0;
    for (int unsigned b = LO; b < HI; b++) begin
      if (shamt_in[b]) begin
        amt          = 32'd1 << b;
        shamt_out[b] = 1'b0;
        unique case (mode)
          SHIFT_LSL: begin
            carry_out = data_out[WIDTH - amt];
            data_out  = data_out << amt;
          end
          SHIFT_LSR: begin
            carry_out = data_out[amt - 1];
            data_out  = data_out >> amt;
          end
          SHIFT_ASR: begin
            carry_out = data_out[amt - 1];
            data_out  = $signed(data_out) >>> amt;
          end
          SHIFT_ROR: begin
            data_out  = (data_out >> amt) | (data_out << (WIDTH - amt));
            carry_out = data_out[WIDTH-1];
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter (LSL / LSR / ASR / ROR) with valid/ready flow
// control on both sides.
// Ports: clk, reset_n (async, active low), flush (sync clear of in-flight ops),
//        bus (barrel_shifter_pipe_if.slave: request and response channels).
// STAGES register stages; stage k applies a contiguous group of shift-amount
// bits (LSB weights first). The final stage register drives the outputs, so
// the latency is exactly STAGES cycles. All stages move together: a stall at
// the output freezes the whole pipeline and deasserts in_ready.
module barrel_shifter_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input logic                 clk,
  input logic                 reset_n,
  input logic                 flush,
  barrel_shifter_pipe_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("barrel_shifter_pipe: WIDTH must be a power of two and at least 4");
  end
  if (STAGES < 1 || STAGES > SHW) begin : g_bad_stages
    $error("barrel_shifter_pipe: STAGES must be in 1..log2(WIDTH)");
  end

  // Stage registers.
  stage_ctrl_t      ctrl_q  [STAGES];
  logic [WIDTH-1:0] data_q  [STAGES];
  logic [SHW-1:0]   shamt_q [STAGES];
  logic             zero_q;

  // Inputs to each combinational stage.
  logic             valid_i [STAGES];
  shift_mode_e      mode_i  [STAGES];
  logic             carry_i [STAGES];
  logic [WIDTH-1:0] data_i  [STAGES];
  logic [SHW-1:0]   shamt_i [STAGES];

  // Outputs of each combinational stage (next value of its register).
  logic [WIDTH-1:0] data_c  [STAGES];
  logic [SHW-1:0]   shamt_c [STAGES];
  logic             carry_c [STAGES];

  logic advance;

  assign advance = bus.out_ready || !ctrl_q[STAGES-1].valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = stage_lo(SHW, STAGES, k);
    localparam int HI = stage_hi(SHW, STAGES, k);

    if (k == 0) begin : g_head
      // Carry starts at 0 so a zero shift amount reports no carry.
      assign valid_i[k] = bus.in_valid;
      assign mode_i[k]  = shift_mode_e'(bus.in_mode);
      assign carry_i[k] = 1'b0;
      assign data_i[k]  = bus.in_data;
      assign shamt_i[k] = bus.in_shamt;
    end else begin : g_body
      assign valid_i[k] = ctrl_q[k-1].valid;
      assign mode_i[k]  = ctrl_q[k-1].mode;
      assign carry_i[k] = ctrl_q[k-1].carry;
      assign data_i[k]  = data_q[k-1];
      assign shamt_i[k] = shamt_q[k-1];
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .LO    (LO),
      .HI    (HI)
    ) u_stage (
      .data_in   (data_i[k]),
      .shamt_in  (shamt_i[k]),
      .mode      (mode_i[k]),
      .carry_in  (carry_i[k]),
      .data_out  (data_c[k]),
      .shamt_out (shamt_c[k]),
      .carry_out (carry_c[k])
    );
  end

  // Flush wins over acceptance: valids clear and the presented input is
  // dropped. Data fields are left as they are since they are only
  // meaningful alongside a set valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        ctrl_q[k]  <= '0;
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
      end
      zero_q <= 1'b0;
    end else if (flush) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        ctrl_q[k].valid <= 1'b0;
      end
    end else if (advance) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        ctrl_q[k].valid <= valid_i[k];
        ctrl_q[k].mode  <= mode_i[k];
        ctrl_q[k].carry <= carry_c[k];
        data_q[k]       <= data_c[k];
        shamt_q[k]      <= shamt_c[k];
      end
      zero_q <= (data_c[STAGES-1] == '0);
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = ctrl_q[STAGES-1].valid;
  assign bus.out_data  = data_q[STAGES-1];
  assign bus.out_carry = ctrl_q[STAGES-1].carry;
  assign bus.out_zero  = zero_q;

  // The final stage's leftover shift amount (always zero) and mode have no
  // consumer downstream.
  logic unused_tail;
  assign unused_tail = ^{shamt_q[STAGES-1], ctrl_q[STAGES-1].mode};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
module tb_barrel_shifter_pipe;

  localparam int STAGES = 2;
  localparam int NCFG   = 7;
  localparam int N_RAND = 1430;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic rand_go = 1'b0;
  int   done_cnt = 0;
  int   n_total = 0;
  int   n_bad = 0;

  logic [15:0] op_d [8];
  logic [3:0]  op_s [8];
  logic [1:0]  op_m [8];

  always #5 clk = ~clk;

  barrel_shifter_pipe_if #(.WIDTH(16)) bus ();

  barrel_shifter_pipe #(.WIDTH(16), .STAGES(STAGES)) u_dut (
    .clk     (clk),
    .reset_n (rst_n),
    .flush   (flush),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: shift of a w-bit value by sh, mode 0 LSL, 1 LSR, 2 ASR, 3 ROR.
  function automatic void ref_shift(input int w, input logic [31:0] d, input int sh,
                                    input int mode, output logic [31:0] r, output logic c);
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    r = d & mask;
    c = 1'b0;
    if (sh != 0) begin
      case (mode)
        0: begin r = (d << sh) & mask; c = d[w - sh]; end
        1: begin r = d >> sh; c = d[sh - 1]; end
        2: begin
          r = d >> sh;
          if (d[w - 1]) r = r | (mask & ~(mask >> sh));
          c = d[sh - 1];
        end
        default: begin r = ((d >> sh) | (d << (w - sh))) & mask; c = r[w - 1]; end
      endcase
    end
  endfunction

  task automatic run_op(input string tag, input logic [15:0] d, input int sh,
                        input logic [1:0] m, input logic [15:0] ed, input logic ec);
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_shamt = 4'(sh); bus.in_mode = m;
    bus.out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check({tag, "_lat"}, lat, STAGES);
    check({tag, "_data"}, bus.out_data, ed);
    check({tag, "_carry"}, bus.out_carry, ec);
    check({tag, "_zero"}, bus.out_zero, ed == 16'h0);
  endtask

  // Streams n ops from the op table; out_ready low during cycles st_lo..st_hi.
  task automatic stream(input string tag, input int n, input int st_lo, input int st_hi);
    int cyc, sent, got;
    logic [15:0] held;
    logic [31:0] r;
    logic c;
    cyc = 0; sent = 0; got = 0; held = '0;
    while ((sent < n || got < n) && cyc < 40) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= st_lo && cyc <= st_hi);
      bus.in_valid  = (sent < n);
      bus.in_data   = op_d[sent & 7];
      bus.in_shamt  = op_s[sent & 7];
      bus.in_mode   = op_m[sent & 7];
      #1;
      if (!bus.out_ready) begin
        check({tag, "_stall_rdy"}, bus.in_ready, 1'b0);
        check({tag, "_stall_vld"}, bus.out_valid, 1'b1);
        if (cyc == st_lo) held = bus.out_data;
        else check({tag, "_stall_hold"}, bus.out_data, held);
      end
      if (bus.out_valid && bus.out_ready) begin
        ref_shift(16, 32'(op_d[got & 7]), int'(op_s[got & 7]), int'(op_m[got & 7]), r, c);
        check({tag, "_data"}, bus.out_data, r[15:0]);
        check({tag, "_carry"}, bus.out_carry, c);
        check({tag, "_zero"}, bus.out_zero, r == 32'h0);
        if (st_lo < 0) check({tag, "_cyc"}, cyc, got + STAGES);
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check({tag, "_count"}, got, n);
    @(negedge clk);
    #1 check({tag, "_no_dup"}, bus.out_valid, 1'b0);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check(tag, seen, 0);
  endtask

  // Randomized configurations: each runs its own DUT against the reference.
  for (genvar g = 0; g < NCFG; g++) begin : g_rand
    localparam int W  = (g < 2) ? 8 : (g < 4) ? 16 : 32;
    localparam int S  = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 2 : (g == 3) ? 4 :
                        (g == 4) ? 5 : (g == 5) ? 3 : 4;
    localparam int SH = $clog2(W);

    barrel_shifter_pipe_if #(.WIDTH(W)) rbus ();
    logic rflush = 1'b0;

    barrel_shifter_pipe #(.WIDTH(W), .STAGES(S)) u_rdut (
      .clk     (clk),
      .reset_n (rst_n),
      .flush   (rflush),
      .bus     (rbus)
    );

    initial begin
      logic [31:0] exp_d [$];
      logic        exp_c [$];
      logic [31:0] r, ed;
      logic        c, ec, stalled, hc;
      logic [W-1:0] hd;
      int acc, got, cyc;
      rbus.in_valid = 1'b0; rbus.in_data = '0; rbus.in_shamt = '0; rbus.in_mode = '0;
      rbus.out_ready = 1'b0;
      acc = 0; got = 0; cyc = 0; stalled = 1'b0; hd = '0; hc = 1'b0;
      wait (rand_go);
      while ((acc < N_RAND || got < acc) && cyc < 20 * N_RAND) begin
        @(negedge clk);
        if (stalled) begin
          check($sformatf("r%0d_hold_vld", g), rbus.out_valid, 1'b1);
          check($sformatf("r%0d_hold_data", g), 64'(rbus.out_data), 64'(hd));
          check($sformatf("r%0d_hold_carry", g), rbus.out_carry, hc);
        end
        rbus.in_valid  = (acc < N_RAND) && ($urandom_range(0, 3) != 0);
        rbus.in_data   = W'($urandom);
        rbus.in_shamt  = SH'($urandom);
        rbus.in_mode   = 2'($urandom);
        rbus.out_ready = ($urandom_range(0, 3) != 0);
        #1;
        stalled = rbus.out_valid && !rbus.out_ready;
        hd = rbus.out_data;
        hc = rbus.out_carry;
        if (rbus.out_valid && rbus.out_ready) begin
          if (exp_d.size() == 0) begin
            check($sformatf("r%0d_extra", g), 1, 0);
          end else begin
            ed = exp_d.pop_front();
            ec = exp_c.pop_front();
            check($sformatf("r%0d_data", g), 64'(rbus.out_data), 64'(ed));
            check($sformatf("r%0d_carry", g), rbus.out_carry, ec);
            check($sformatf("r%0d_zero", g), rbus.out_zero, ed == 32'h0);
          end
          got++;
        end
        if (rbus.in_valid && rbus.in_ready) begin
          ref_shift(W, 32'(rbus.in_data), int'(rbus.in_shamt), int'(rbus.in_mode), r, c);
          exp_d.push_back(r);
          exp_c.push_back(c);
          acc++;
        end
        cyc++;
      end
      rbus.in_valid = 1'b0;
      check($sformatf("r%0d_accepted", g), acc, N_RAND);
      check($sformatf("r%0d_drained", g), got, acc);
      done_cnt++;
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_shamt = '0; bus.in_mode = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op_d[i] = 16'($urandom); op_s[i] = 4'($urandom); op_m[i] = 2'($urandom);
    end
    op_d[3] = 16'h0001; op_s[3] = 4'd1; op_m[3] = 2'b01;

    repeat (3) @(negedge clk);
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_data", bus.out_data, 16'h0);
    check("rst_carry", bus.out_carry, 1'b0);
    check("rst_zero", bus.out_zero, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b1);

    run_op("lsl_8001", 16'h8001, 1, 2'b00, 16'h0002, 1'b1);
    run_op("asr_8000", 16'h8000, 15, 2'b10, 16'hFFFF, 1'b0);
    run_op("lsr_8000", 16'h8000, 15, 2'b01, 16'h0001, 1'b0);
    run_op("ror_0001", 16'h0001, 4, 2'b11, 16'h1000, 1'b0);
    run_op("ror_0008", 16'h0008, 4, 2'b11, 16'h8000, 1'b1);
    run_op("lsr_0001", 16'h0001, 1, 2'b01, 16'h0000, 1'b1);
    run_op("sh0_asr", 16'hA5C3, 0, 2'b10, 16'hA5C3, 1'b0);
    run_op("lsl_max", 16'h0003, 15, 2'b00, 16'h8000, 1'b1);

    stream("b2b", 8, -1, -2);
    stream("bp", 4, 2, 4);

    // Flush with an op in flight and a new op presented the same cycle.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 16'h1234; bus.in_shamt = 4'd3; bus.in_mode = 2'b00;
    @(negedge clk);
    check("flush_in_ready", bus.in_ready, 1'b1);
    flush = 1'b1; bus.in_data = 16'h5678;
    @(negedge clk);
    flush = 1'b0; bus.in_valid = 1'b0;
    watch_quiet("flush_quiet", 5);
    run_op("after_flush", 16'h00F0, 4, 2'b01, 16'h000F, 1'b0);

    // Reset pulse with ops in flight.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 16'h8421; bus.in_shamt = 4'd2; bus.in_mode = 2'b10;
    @(negedge clk);
    bus.in_data = 16'h1111;
    #2 rst_n = 1'b0; bus.in_valid = 1'b0;
    #1 check("rst_mid_valid", bus.out_valid, 1'b0);
    check("rst_mid_data", bus.out_data, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_mid_ready", bus.in_ready, 1'b1);
    watch_quiet("rst_quiet", 5);
    run_op("after_rst", 16'hF00F, 8, 2'b11, 16'h0FF0, 1'b0);

    rand_go = 1'b1;
    for (int t = 0; t < 40000 && done_cnt < NCFG; t++) @(negedge clk);
    check("rand_done", done_cnt, NCFG);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
